// File: rtl/regfile_pkg.sv
// Shared constants and scrub FSM encoding for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: zero-register override, write-to-read forwarding and busy lookup.
module regfile_read_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              rst,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] entry,
  input  logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);

  logic hit0, hit1, hit_rsv, fwd;

  always_comb begin
    hit0    = we0 && (waddr0 == raddr);
    hit1    = we1 && (waddr1 == raddr);
    hit_rsv = rsv_en && (rsv_addr == raddr);
    fwd     = (BYPASS != 0) && byp_en;

    rdata = entry;
    if (fwd && hit1)      rdata = wdata1;
    else if (fwd && hit0) rdata = wdata0;

    // A retiring producer releases the entry unless a new one claims it now.
    rbusy = busy;
    if (fwd && (hit0 || hit1) && !hit_rsv) rbusy = 1'b0;

    if (rst || ((ZERO_R0 != 0) && (raddr == '0))) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard and a one-entry-per-cycle scrub engine.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_e                        state_q;
  logic [ADDR_W-1:0]             idx_q;
  logic                          clr_busy_q;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [DEPTH-1:0]              busy_q, busy_d;
  logic                          idle, we0_ok, we1_ok, rsv_ok;

  // Address-0 traffic is discarded up front so array, scoreboard and bypass agree.
  always_comb begin
    idle   = (state_q == ST_IDLE);
    we0_ok = idle && we0    && !((ZERO_R0 != 0) && (waddr0   == '0));
    we1_ok = idle && we1    && !((ZERO_R0 != 0) && (waddr1   == '0));
    rsv_ok = idle && rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));
  end

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (!idle) begin
      mem_d[idx_q]  = '0;
      busy_d[idx_q] = 1'b0;
    end else begin
      if (we0_ok) begin
        mem_d[waddr0]  = wdata0;
        busy_d[waddr0] = 1'b0;
      end
      if (we1_ok) begin
        mem_d[waddr1]  = wdata1;
        busy_d[waddr1] = 1'b0;
      end
      if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          idx_q      <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;
  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_rd (
      .rst     (rst),
      .byp_en  (idle),
      .raddr   (ra),
      .entry   (mem_q[ra]),
      .busy    (busy_q[ra]),
      .we0     (we0_ok),
      .waddr0  (waddr0),
      .wdata0  (wdata0),
      .we1     (we1_ok),
      .waddr1  (waddr1),
      .wdata1  (wdata1),
      .rsv_en  (rsv_ok),
      .rsv_addr(rsv_addr),
      .rdata   (rdata[i*DATA_W +: DATA_W]),
      .rbusy   (rbusy[i])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default file, a no-bypass twin sharing its inputs, and a 32x32 zero-register variant.
module tb_register_file_mp;

  logic        clk, rst;
  logic        we0, we1, rsv_en, clr_req;
  logic [2:0]  waddr0, waddr1, rsv_addr;
  logic [15:0] wdata0, wdata1;
  logic [5:0]  raddr;
  logic [31:0] rdata, nb_rdata;
  logic [1:0]  rbusy, nb_rbusy;
  logic        clr_busy, nb_clr_busy;
  logic [7:0]  busy_vec, nb_busy_vec;

  logic        z_we0, z_we1, z_rsv_en, z_clr_req;
  logic [4:0]  z_waddr0, z_waddr1, z_rsv_addr;
  logic [31:0] z_wdata0, z_wdata1;
  logic [14:0] z_raddr;
  logic [95:0] z_rdata;
  logic [2:0]  z_rbusy;
  logic        z_clr_busy;
  logic [31:0] z_busy_vec;

  int n_chk = 0;
  int n_fail = 0;

  register_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata),
    .rbusy(rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
    .clr_busy(clr_busy), .busy_vec(busy_vec));

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(nb_rdata),
    .rbusy(nb_rbusy), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
    .clr_busy(nb_clr_busy), .busy_vec(nb_busy_vec));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_R0(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst(rst), .we0(z_we0), .waddr0(z_waddr0), .wdata0(z_wdata0),
    .we1(z_we1), .waddr1(z_waddr1), .wdata1(z_wdata1), .raddr(z_raddr), .rdata(z_rdata),
    .rbusy(z_rbusy), .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .clr_req(z_clr_req),
    .clr_busy(z_clr_busy), .busy_vec(z_busy_vec));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 0; we1 = 0; rsv_en = 0; clr_req = 0;
    waddr0 = 0; waddr1 = 0; rsv_addr = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    z_we0 = 0; z_we1 = 0; z_rsv_en = 0; z_clr_req = 0;
    z_waddr0 = 0; z_waddr1 = 0; z_rsv_addr = 0; z_wdata0 = 0; z_wdata1 = 0; z_raddr = 0;
    // Write to the addressed entry while reset is held: nothing may leak out.
    we0 = 1; waddr0 = 3'd2; wdata0 = 16'h1234; raddr = {3'd2, 3'd2};
    #3;
    n_chk++;
    if (rdata !== 32'h0 || rbusy !== 2'b00) begin
      n_fail++; $display("FAIL reset_bypass_gated: rdata=%h rbusy=%b want 0/0", rdata, rbusy);
    end
    cyc();
    #2 rst = 0;
    idle_inputs();
    for (int a = 0; a < 8; a += 2) begin
      raddr = {3'(a + 1), 3'(a)};
      #1;
      n_chk++;
      if (rdata !== 32'h0 || rbusy !== 2'b00) begin
        n_fail++; $display("FAIL reset_read a=%0d: rdata=%h rbusy=%b want 0", a, rdata, rbusy);
      end
    end
    n_chk++;
    if (busy_vec !== 8'h0 || clr_busy !== 1'b0 || z_busy_vec !== 32'h0 || z_rdata !== 96'h0) begin
      n_fail++; $display("FAIL reset_state: busy_vec=%h clr_busy=%b z_busy=%h want 0", busy_vec, clr_busy, z_busy_vec);
    end
  endtask

  task automatic test_write_prio();
    cyc();
    we0 = 1; waddr0 = 3'd3; wdata0 = 16'h1234;
    we1 = 1; waddr1 = 3'd3; wdata1 = 16'hBEEF;
    raddr = {3'd1, 3'd3};
    #1;
    n_chk++;
    if (rdata[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL bypass_prio: got %h want beef", rdata[15:0]);
    end
    n_chk++;
    if (nb_rdata[15:0] !== 16'h0000) begin
      n_fail++; $display("FAIL nobypass_old: got %h want 0000", nb_rdata[15:0]);
    end
    cyc();
    idle_inputs();
    #1;
    n_chk++;
    if (rdata[15:0] !== 16'hBEEF || nb_rdata[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_prio_stored: got %h/%h want beef", rdata[15:0], nb_rdata[15:0]);
    end
    we0 = 1; waddr0 = 3'd1; wdata0 = 16'h1111;
    we1 = 1; waddr1 = 3'd2; wdata1 = 16'h2222;
    cyc();
    idle_inputs();
    raddr = {3'd2, 3'd1};
    #1;
    n_chk++;
    if (nb_rdata !== 32'h2222_1111) begin
      n_fail++; $display("FAIL dual_write: got %h want 22221111", nb_rdata);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_addr = 3'd5; raddr = {3'd0, 3'd5};
    #1;
    n_chk++;
    if (busy_vec !== 8'h00) begin
      n_fail++; $display("FAIL rsv_not_early: busy_vec=%h want 00", busy_vec);
    end
    cyc();
    rsv_en = 0;
    #1;
    n_chk++;
    if (busy_vec !== 8'h20 || rbusy[0] !== 1'b1) begin
      n_fail++; $display("FAIL rsv_set: busy_vec=%h rbusy0=%b want 20/1", busy_vec, rbusy[0]);
    end
    we0 = 1; waddr0 = 3'd5; wdata0 = 16'h00AA; rsv_en = 1; rsv_addr = 3'd5;
    #1;
    n_chk++;
    if (rbusy[0] !== 1'b1) begin
      n_fail++; $display("FAIL rsv_write_rbusy: got %b want 1", rbusy[0]);
    end
    cyc();
    rsv_en = 0;
    #1;
    n_chk++;
    if (busy_vec !== 8'h20) begin
      n_fail++; $display("FAIL rsv_write_busy: busy_vec=%h want 20", busy_vec);
    end
    wdata0 = 16'h00BB;
    #1;
    n_chk++;
    if (rbusy[0] !== 1'b0 || nb_rbusy[0] !== 1'b1 || rdata[15:0] !== 16'h00BB) begin
      n_fail++; $display("FAIL release_bypass: rbusy=%b nb_rbusy=%b rdata=%h want 0/1/00bb", rbusy[0], nb_rbusy[0], rdata[15:0]);
    end
    cyc();
    idle_inputs();
    #1;
    n_chk++;
    if (busy_vec !== 8'h00 || nb_busy_vec !== 8'h00) begin
      n_fail++; $display("FAIL release: busy_vec=%h nb=%h want 00", busy_vec, nb_busy_vec);
    end
  endtask

  task automatic test_scrub();
    for (int k = 0; k < 8; k++) begin
      we0 = 1; waddr0 = 3'(k); wdata0 = 16'hFFFF;
      if (k == 7) begin
        rsv_en = 1; rsv_addr = 3'd2; clr_req = 1;
        #1;
        n_chk++;
        if (clr_busy !== 1'b0) begin
          n_fail++; $display("FAIL clr_req_cycle: clr_busy=%b want 0", clr_busy);
        end
      end
      cyc();
    end
    idle_inputs();
    n_chk++;
    if (busy_vec !== 8'h04) begin
      n_fail++; $display("FAIL rsv_with_clr_req: busy_vec=%h want 04", busy_vec);
    end
    for (int j = 0; j < 8; j++) begin
      if (j == 3) begin we0 = 1; waddr0 = 3'd0; wdata0 = 16'h1234; end
      if (j == 4) we0 = 0;
      clr_req = (j == 5);
      raddr = {(j == 3) ? 3'd0 : 3'(j - 1), 3'(j)};
      #1;
      n_chk++;
      if (clr_busy !== 1'b1 || rdata[15:0] !== 16'hFFFF) begin
        n_fail++; $display("FAIL scrub_cycle j=%0d: clr_busy=%b rdata0=%h want 1/ffff", j, clr_busy, rdata[15:0]);
      end
      if (j > 0) begin
        n_chk++;
        if (rdata[31:16] !== 16'h0000) begin
          n_fail++; $display("FAIL scrub_cleared j=%0d: rdata1=%h want 0000", j, rdata[31:16]);
        end
      end
      cyc();
    end
    idle_inputs();
    n_chk++;
    if (clr_busy !== 1'b0 || busy_vec !== 8'h00) begin
      n_fail++; $display("FAIL scrub_done: clr_busy=%b busy_vec=%h want 0/00", clr_busy, busy_vec);
    end
    for (int a = 0; a < 8; a += 2) begin
      raddr = {3'(a + 1), 3'(a)};
      #1;
      n_chk++;
      if (nb_rdata !== 32'h0) begin
        n_fail++; $display("FAIL scrub_zero a=%0d: rdata=%h want 0", a, nb_rdata);
      end
    end
    cyc();
    n_chk++;
    if (clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_req_ignored: clr_busy=%b want 0", clr_busy);
    end
    we0 = 1; waddr0 = 3'd4; wdata0 = 16'h4444;
    cyc();
    idle_inputs();
    raddr = {3'd0, 3'd4};
    #1;
    n_chk++;
    if (nb_rdata[15:0] !== 16'h4444) begin
      n_fail++; $display("FAIL idle_after_scrub: got %h want 4444", nb_rdata[15:0]);
    end
  endtask

  task automatic test_reset_mid_scrub();
    we0 = 1; waddr0 = 3'd6; wdata0 = 16'h6666; rsv_en = 1; rsv_addr = 3'd5;
    cyc();
    idle_inputs();
    clr_req = 1;
    cyc();
    clr_req = 0;
    cyc();
    cyc();
    raddr = {3'd4, 3'd6};
    #1;
    n_chk++;
    if (clr_busy !== 1'b1 || rdata !== 32'h4444_6666 || busy_vec !== 8'h20) begin
      n_fail++; $display("FAIL pre_abort: clr_busy=%b rdata=%h busy=%h want 1/44446666/20", clr_busy, rdata, busy_vec);
    end
    rst = 1;
    #1;
    n_chk++;
    if (clr_busy !== 1'b0 || rdata !== 32'h0 || busy_vec !== 8'h00) begin
      n_fail++; $display("FAIL abort: clr_busy=%b rdata=%h busy=%h want 0/0/00", clr_busy, rdata, busy_vec);
    end
    cyc();
    #2 rst = 0;
    we0 = 1; waddr0 = 3'd6; wdata0 = 16'h0606;
    cyc();
    idle_inputs();
    #1;
    n_chk++;
    if (clr_busy !== 1'b0 || nb_rdata[15:0] !== 16'h0606) begin
      n_fail++; $display("FAIL idle_after_abort: clr_busy=%b rdata=%h want 0/0606", clr_busy, nb_rdata[15:0]);
    end
  endtask

  task automatic test_zero_reg();
    z_we0 = 1; z_waddr0 = 5'd0; z_wdata0 = 32'hDEADBEEF;
    z_rsv_en = 1; z_rsv_addr = 5'd0; z_raddr = {5'd0, 5'd0, 5'd0};
    #1;
    n_chk++;
    if (z_rdata !== 96'h0 || z_rbusy !== 3'b000) begin
      n_fail++; $display("FAIL zero_bypass: rdata=%h rbusy=%b want 0", z_rdata, z_rbusy);
    end
    cyc();
    z_we0 = 0; z_rsv_en = 0;
    #1;
    n_chk++;
    if (z_busy_vec !== 32'h0 || z_rdata[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL zero_store: busy=%h rdata0=%h want 0", z_busy_vec, z_rdata[31:0]);
    end
    z_we1 = 1; z_waddr1 = 5'd31; z_wdata1 = 32'hCAFEF00D; z_raddr = {5'd31, 5'd31, 5'd31};
    #1;
    n_chk++;
    if (z_rdata !== {3{32'hCAFEF00D}}) begin
      n_fail++; $display("FAIL z_bypass31: rdata=%h want cafef00d x3", z_rdata);
    end
    cyc();
    z_we1 = 0;
    #1;
    n_chk++;
    if (z_rdata !== {3{32'hCAFEF00D}}) begin
      n_fail++; $display("FAIL z_stored31: rdata=%h want cafef00d x3", z_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_prio();
    test_scoreboard();
    test_scrub();
    test_reset_mid_scrub();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port general register file, successor to the 8x16 two-read/one-write file.
- Generalised in data width, depth and read-port count.
- Adds a second write port with defined priority, optional hard-wired zero register and optional write-to-read bypass.
- Adds a per-entry busy scoreboard for hazard detection and a sequential scrub engine that clears the array one entry per cycle.
- Sits between decode (read/reserve) and writeback (write/release) in the processor datapath.

Parameters:
- DATA_W, 16, entry width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (derived localparam)
- NUM_RD, 2, number of read ports
- ZERO_R0, 0, 1 = entry 0 reads as 0; writes and reservations to address 0 are discarded
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  busy flag of the entry addressed by each read port
- rsv_en  in  1  reserve: mark rsv_addr busy (pending producer)
- rsv_addr  in  ADDR_W  entry to reserve
- clr_req  in  1  one-cycle pulse: start scrub of the whole array
- clr_busy  out  1  scrub in progress; caller must stall writes and reservations
- busy_vec  out  DEPTH  full scoreboard, bit k = entry k busy

Behaviour:
Reset (rst=1, asynchronous):
- All entries and busy bits 0; FSM to IDLE; scrub index 0; clr_busy=0.
- rdata=0 and rbusy=0 while reset is held.
- Assertion mid-scrub aborts the scrub immediately.

Writes (IDLE only):
- On clk rising edge, weN=1 stores wdataN at waddrN.
- we0 and we1 to the same address: port 1 value is stored.
- Different addresses: both are stored.
- ZERO_R0=1: writes to address 0 are dropped.

Reads:
- Combinational, zero latency.
- BYPASS=1, IDLE, and some weN=1 with waddrN==raddr_i: rdata_i = wdataN (port 1 wins if both match).
- Otherwise rdata_i = stored entry. ZERO_R0=1 and raddr_i=0: rdata_i = 0 always.

Scoreboard:
- rsv_en sets busy[rsv_addr] at the next edge.
- A write to address k clears busy[k] at the next edge.
- rsv and write to the same address in the same cycle: busy ends set (new producer wins).
- rbusy_i = busy[raddr_i]. When BYPASS=1, it is 0 if a write to raddr_i occurs this cycle without a same-cycle reservation of that address.
- busy_vec is the registered scoreboard, with no bypass.

Scrub FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on clr_req=1. Writes and reservations presented in that same cycle are still performed.
- CLEAR: each cycle, entry[idx] <= 0 and busy[idx] <= 0, then idx <= idx+1.
- CLEAR -> IDLE after idx == DEPTH-1; idx returns to 0.
- Scrub takes exactly DEPTH cycles. clr_busy=1 for exactly those DEPTH cycles (registered, state==CLEAR).
- During CLEAR: we0/we1/rsv_en are ignored, clr_req is ignored, and bypass is disabled.
- Reads during CLEAR return current array contents: cleared entries read 0, uncleared entries read their old values.

Widths:
- Addresses are unsigned and used directly as the index; no wrap is needed since DEPTH = 2**ADDR_W.
- idx is ADDR_W bits.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants and the FSM state enum (ST_IDLE, ST_CLEAR).
- Sub-module regfile_read_port: one per read port via generate. Contains the bypass/zero-register mux and rbusy logic; inputs are array entry, busy bit and both write ports.
- Top level holds the array, scoreboard, write priority and scrub FSM.

Test Plan:
- Reset then read all addresses -> rdata=0, rbusy=0, busy_vec=0, clr_busy=0.
- we0 addr3=0x1234 and we1 addr3=0xBEEF in the same cycle, raddr0=3 -> rdata0=0xBEEF in that cycle (BYPASS=1), entry 3 = 0xBEEF afterwards; with BYPASS=0, rdata0 = old value that cycle.
- rsv_en addr5 -> busy_vec[5]=1 next cycle. Then we0 addr5=0x00AA with rsv_en addr5 in the same cycle -> busy stays 1. Then a write alone -> busy 0.
- Load all 8 entries with 0xFFFF, pulse clr_req -> clr_busy high for exactly 8 cycles; entry k reads 0 from cycle k+1; we0 issued during CLEAR has no effect; IDLE afterwards.
- Assert rst in the 4th cycle of a scrub -> clr_busy=0 and all entries 0 immediately; state IDLE after release.
- ZERO_R0=1, DATA_W=32, ADDR_W=5, NUM_RD=3: write 0xDEADBEEF to addr 0 and rsv addr 0 -> read 0, busy_vec[0]=0. Write addr 31 -> readable on all 3 ports.
